// File: rtl/agnus_audio_dma_ctrl_pkg.sv
// Shared constants for the Agnus audio DMA engine: audio register byte
// addresses, default beam positions for the strobe and the fetch slots,
// and the idle destination-register code.
package agnus_audio_dma_ctrl_pkg;

  localparam int NUM_CH = 4;

  // Which of a channel's registers an address refers to.
  typedef enum logic [1:0] {
    AUD_LCH = 2'd0,
    AUD_LCL = 2'd1,
    AUD_DAT = 2'd2
  } aud_reg_e;

  // Register byte addresses (bit 0 always zero).
  localparam logic [8:0] AUD0LCH = 9'h0A0;
  localparam logic [8:0] AUD0LCL = 9'h0A2;
  localparam logic [8:0] AUD0DAT = 9'h0AA;
  localparam logic [8:0] AUD1LCH = 9'h0B0;
  localparam logic [8:0] AUD1LCL = 9'h0B2;
  localparam logic [8:0] AUD1DAT = 9'h0BA;
  localparam logic [8:0] AUD2LCH = 9'h0C0;
  localparam logic [8:0] AUD2LCL = 9'h0C2;
  localparam logic [8:0] AUD2DAT = 9'h0CA;
  localparam logic [8:0] AUD3LCH = 9'h0D0;
  localparam logic [8:0] AUD3LCL = 9'h0D2;
  localparam logic [8:0] AUD3DAT = 9'h0DA;

  // Default beam positions: channel x is fetched at SLOT_BASE + 2*x.
  localparam logic [8:0] SLOT_BASE_DEF  = 9'h00E;
  localparam logic [8:0] STRHOR_POS_DEF = 9'h002;

  // reg_address_out value while no audio fetch owns the bus.
  localparam logic [7:0] REG_IDLE = 8'hFF;

  // Byte address of register 'kind' of channel 'ch'.
  function automatic logic [8:0] aud_byte_addr(input aud_reg_e kind, input logic [1:0] ch);
    logic [8:0] addr;
    addr = 9'h000;
    case (kind)
      AUD_LCH: begin
        case (ch)
          2'd0:    addr = AUD0LCH;
          2'd1:    addr = AUD1LCH;
          2'd2:    addr = AUD2LCH;
          default: addr = AUD3LCH;
        endcase
      end
      AUD_LCL: begin
        case (ch)
          2'd0:    addr = AUD0LCL;
          2'd1:    addr = AUD1LCL;
          2'd2:    addr = AUD2LCL;
          default: addr = AUD3LCL;
        endcase
      end
      default: begin
        case (ch)
          2'd0:    addr = AUD0DAT;
          2'd1:    addr = AUD1DAT;
          2'd2:    addr = AUD2DAT;
          default: addr = AUD3DAT;
        endcase
      end
    endcase
    return addr;
  endfunction

  // Register bus carries word addresses [8:1].
  function automatic logic [7:0] reg_word(input logic [8:0] byte_addr);
    return byte_addr[8:1];
  endfunction

endpackage

// File: rtl/agnus_audio_ptr.sv
// One audio channel's location register (AUDxLC) and running pointer
// (AUDxPT). Decodes its own LCH/LCL writes and advances or reloads the
// pointer when its fetch slot is serviced.
module agnus_audio_ptr
  import agnus_audio_dma_ctrl_pkg::*;
#(
  parameter logic [1:0] CHAN = 2'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk7_en,
  input  logic        aen,
  input  logic [7:0]  reg_address_in,
  input  logic [15:0] data_in,
  input  logic        service,
  input  logic        restart,
  output logic [19:0] fetch_address
);

  localparam logic [7:0] LCH_REG = reg_word(aud_byte_addr(AUD_LCH, CHAN));
  localparam logic [7:0] LCL_REG = reg_word(aud_byte_addr(AUD_LCL, CHAN));

  // Word addresses [20:1] held as [19:0].
  logic [19:0] lc_reg;
  logic [19:0] pt_reg;

  // A restart fetch comes from the location register, otherwise the pointer.
  assign fetch_address = restart ? lc_reg : pt_reg;

  // LC writes and pointer advance; the fetch sees the pre-write lc value.
  always_ff @(posedge clk) begin
    if (clk7_en) begin
      if (reset) begin
        lc_reg <= '0;
        pt_reg <= '0;
      end else begin
        if (aen && reg_address_in == LCH_REG) begin
          lc_reg[19:15] <= data_in[4:0];
        end
        if (aen && reg_address_in == LCL_REG) begin
          lc_reg[14:0] <= data_in[15:1];
        end
        if (service) begin
          pt_reg <= fetch_address + 20'd1;
        end
      end
    end
  end

endmodule

// File: rtl/agnus_audio_dma_ctrl.sv
// Agnus audio DMA engine: samples the four channels' requests at the
// horizontal strobe and drives one chip-RAM fetch per requesting channel in
// its fixed slot, addressed to that channel's AUDxDAT register.
module agnus_audio_dma_ctrl
  import agnus_audio_dma_ctrl_pkg::*;
#(
  parameter logic [8:0] SLOT_BASE  = SLOT_BASE_DEF,
  parameter logic [8:0] STRHOR_POS = STRHOR_POS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk7_en,
  input  logic        cck,
  input  logic [8:0]  hpos,
  input  logic [3:0]  audio_en,
  input  logic [3:0]  dmareq,
  input  logic [3:0]  dmas,
  input  logic        aen,
  input  logic [7:0]  reg_address_in,
  input  logic [15:0] data_in,
  output logic        strhor,
  output logic        dma,
  output logic [19:0] address_out,
  output logic [7:0]  reg_address_out
);

  logic [3:0]  pend_reg;
  logic [3:0]  pend_next;
  logic [3:0]  pends_reg;
  logic [3:0]  pends_next;
  logic [3:0]  slot_active;
  logic [19:0] fetch_addr [NUM_CH];

  assign strhor = (hpos == STRHOR_POS);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
      localparam logic [8:0] SLOT_HPOS = SLOT_BASE + 9'(2 * gi);

      assign slot_active[gi] = (hpos == SLOT_HPOS) && pend_reg[gi];

      agnus_audio_ptr #(
        .CHAN(2'(gi))
      ) u_ptr (
        .clk            (clk),
        .reset          (reset),
        .clk7_en        (clk7_en),
        .aen            (aen),
        .reg_address_in (reg_address_in),
        .data_in        (data_in),
        .service        (cck && slot_active[gi]),
        .restart        (pends_reg[gi]),
        .fetch_address  (fetch_addr[gi])
      );
    end
  endgenerate

  // Pending-request bookkeeping: service/cancel clears, strobe latch wins.
  always_comb begin
    pend_next  = pend_reg;
    pends_next = pends_reg;
    for (int i = 0; i < NUM_CH; i++) begin
      if ((cck && slot_active[i]) || !audio_en[i]) begin
        pend_next[i]  = 1'b0;
        pends_next[i] = 1'b0;
      end
    end
    if (cck && strhor) begin
      pend_next  = dmareq & audio_en;
      pends_next = dmas;
    end
  end

  // Request state register; reset, like every update, waits for clk7_en.
  always_ff @(posedge clk) begin
    if (clk7_en) begin
      if (reset) begin
        pend_reg  <= '0;
        pends_reg <= '0;
      end else begin
        pend_reg  <= pend_next;
        pends_reg <= pends_next;
      end
    end
  end

  // Bus outputs follow hpos combinationally; at most one slot matches.
  always_comb begin
    dma             = 1'b0;
    address_out     = '0;
    reg_address_out = REG_IDLE;
    for (int i = 0; i < NUM_CH; i++) begin
      if (slot_active[i]) begin
        dma             = 1'b1;
        address_out     = fetch_addr[i];
        reg_address_out = reg_word(aud_byte_addr(AUD_DAT, 2'(i)));
      end
    end
  end

endmodule

// File: tb/tb_agnus_audio_dma_ctrl.sv
// Self-checking bench for agnus_audio_dma_ctrl: directed scenarios followed
// by randomized lines, every cycle compared with a behavioural model.
module tb_agnus_audio_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset_v;
  logic        ce_v;
  logic        cck_v;
  logic [8:0]  hpos_v;
  logic [3:0]  en_v;
  logic [3:0]  req_v;
  logic [3:0]  dmas_v;
  logic        aen_v;
  logic [7:0]  ra_v;
  logic [15:0] data_v;
  logic        strhor;
  logic        dma;
  logic [19:0] address_out;
  logic [7:0]  reg_address_out;

  always #5 clk = ~clk;

  agnus_audio_dma_ctrl dut (
    .clk             (clk),
    .reset           (reset_v),
    .clk7_en         (ce_v),
    .cck             (cck_v),
    .hpos            (hpos_v),
    .audio_en        (en_v),
    .dmareq          (req_v),
    .dmas            (dmas_v),
    .aen             (aen_v),
    .reg_address_in  (ra_v),
    .data_in         (data_v),
    .strhor          (strhor),
    .dma             (dma),
    .address_out     (address_out),
    .reg_address_out (reg_address_out)
  );

  // Behavioural model state (word addresses).
  logic [19:0] m_lc [4];
  logic [19:0] m_pt [4];
  bit          m_pend [4];
  bit          m_restart [4];

  int          n_checks = 0;
  int          n_pass = 0;
  logic [19:0] last_addr;
  int          dma_cycles;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // One clk cycle: compare outputs from model, then advance model at the edge.
  task automatic tick();
    bit          e_dma;
    logic [19:0] e_addr;
    logic [7:0]  e_reg;
    logic [19:0] new_lc [4];
    int          b;
    int          ch;
    #1;
    e_dma  = 1'b0;
    e_addr = 20'h0;
    e_reg  = 8'hFF;
    for (int x = 0; x < 4; x++) begin
      if (int'(hpos_v) == 14 + 2 * x && m_pend[x]) begin
        e_dma  = 1'b1;
        e_addr = m_restart[x] ? m_lc[x] : m_pt[x];
        e_reg  = 8'((170 + 16 * x) / 2);
      end
    end
    check("strhor", 32'(strhor), 32'(int'(hpos_v) == 2));
    check("dma", 32'(dma), 32'(e_dma));
    check("address_out", 32'(address_out), 32'(e_addr));
    check("reg_address_out", 32'(reg_address_out), 32'(e_reg));
    if (dma) begin
      last_addr = address_out;
      dma_cycles++;
      if (cck_v && ce_v)
        $display("fetch hpos=%h addr=%h reg=%h", hpos_v, address_out, reg_address_out);
    end
    @(posedge clk);
    if (ce_v) begin
      if (reset_v) begin
        for (int x = 0; x < 4; x++) begin
          m_lc[x] = '0; m_pt[x] = '0; m_pend[x] = 0; m_restart[x] = 0;
        end
      end else begin
        for (int x = 0; x < 4; x++) new_lc[x] = m_lc[x];
        if (aen_v) begin
          b = 2 * int'(ra_v);
          if (b >= 160 && b < 224) begin
            ch = (b - 160) / 16;
            if (b % 16 == 0)
              new_lc[ch] = (m_lc[ch] & 20'h07FFF) | (20'(data_v & 16'h001F) << 15);
            else if (b % 16 == 2)
              new_lc[ch] = (m_lc[ch] & 20'hF8000) | 20'(data_v / 2);
          end
        end
        for (int x = 0; x < 4; x++) begin
          if (cck_v && int'(hpos_v) == 14 + 2 * x && m_pend[x]) begin
            m_pt[x] = 20'((m_restart[x] ? m_lc[x] : m_pt[x]) + 20'd1);
            m_pend[x] = 0; m_restart[x] = 0;
          end else if (!en_v[x]) begin
            m_pend[x] = 0; m_restart[x] = 0;
          end
        end
        if (cck_v && int'(hpos_v) == 2) begin
          for (int x = 0; x < 4; x++) begin
            m_pend[x]    = req_v[x] && en_v[x];
            m_restart[x] = dmas_v[x];
          end
        end
        for (int x = 0; x < 4; x++) m_lc[x] = new_lc[x];
      end
    end
    @(negedge clk);
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [15:0] d);
    hpos_v = 9'h100; cck_v = 1'b0; ce_v = 1'b1; reset_v = 1'b0;
    aen_v = 1'b1; ra_v = a; data_v = d;
    tick();
    aen_v = 1'b0;
  endtask

  // One 24-colour-clock line; en1 applies after the strobe; optional write at wr_hp.
  task automatic run_line(input logic [3:0] req, input logic [3:0] dm, input logic [3:0] en0,
                          input logic [3:0] en1, input logic [8:0] wr_hp, input logic [7:0] wr_a,
                          input logic [15:0] wr_d, input bit rnd);
    last_addr  = 20'hDEAD0;
    dma_cycles = 0;
    for (int hp = 0; hp < 24; hp++) begin
      for (int ph = 0; ph < 2; ph++) begin
        hpos_v  = 9'(hp);
        cck_v   = (ph == 1);
        en_v    = (hp >= 3) ? en1 : en0;
        req_v   = req;
        dmas_v  = dm;
        aen_v   = (ph == 1) && (9'(hp) == wr_hp);
        ra_v    = wr_a;
        data_v  = wr_d;
        ce_v    = rnd ? ($urandom_range(0, 9) != 0) : 1'b1;
        reset_v = rnd ? ($urandom_range(0, 399) == 0) : 1'b0;
        tick();
      end
    end
    aen_v = 1'b0; reset_v = 1'b0; ce_v = 1'b1;
  endtask

  initial begin
    logic [7:0] ra;
    int         sel;
    for (int x = 0; x < 4; x++) begin
      m_lc[x] = '0; m_pt[x] = '0; m_pend[x] = 0; m_restart[x] = 0;
    end
    reset_v = 1'b1; ce_v = 1'b1; cck_v = 1'b0; hpos_v = 9'h0;
    en_v = 4'h0; req_v = 4'h0; dmas_v = 4'h0; aen_v = 1'b0; ra_v = 8'h0; data_v = 16'h0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) tick();
    reset_v = 1'b0;
    check("rst_reg_idle", 32'(reg_address_out), 32'h0FF);
    check("rst_addr", 32'(address_out), 32'h0);

    // Restart fetch on channel 0, then a pointer fetch.
    write_reg(8'h50, 16'h0003);
    write_reg(8'h51, 16'h4000);
    run_line(4'h1, 4'h1, 4'h1, 4'h1, 9'h1FF, 8'h00, 16'h0, 1'b0);
    check("ch0_restart_addr", 32'(last_addr), 32'h1A000);
    run_line(4'h1, 4'h0, 4'h1, 4'h1, 9'h1FF, 8'h00, 16'h0, 1'b0);
    check("ch0_ptr_addr", 32'(last_addr), 32'h1A001);

    // All four channels: two clk cycles of dma per slot.
    run_line(4'hF, 4'h0, 4'hF, 4'hF, 9'h1FF, 8'h00, 16'h0, 1'b0);
    check("all_ch_dma_cycles", 32'(dma_cycles), 32'd8);

    // Channel 2 disabled after the strobe: cancelled, pointer kept.
    run_line(4'h4, 4'h0, 4'h4, 4'h0, 9'h1FF, 8'h00, 16'h0, 1'b0);
    check("ch2_cancel_dma", 32'(dma_cycles), 32'd0);
    run_line(4'h4, 4'h0, 4'h4, 4'h4, 9'h1FF, 8'h00, 16'h0, 1'b0);
    check("ch2_ptr_kept", 32'(last_addr), 32'h00001);

    // Channel 1 pointer wrap.
    write_reg(8'h58, 16'h001F);
    write_reg(8'h59, 16'hFFFC);
    run_line(4'h2, 4'h2, 4'h2, 4'h2, 9'h1FF, 8'h00, 16'h0, 1'b0);
    run_line(4'h2, 4'h0, 4'h2, 4'h2, 9'h1FF, 8'h00, 16'h0, 1'b0);
    check("ch1_top_addr", 32'(last_addr), 32'hFFFFF);
    run_line(4'h2, 4'h0, 4'h2, 4'h2, 9'h1FF, 8'h00, 16'h0, 1'b0);
    check("ch1_wrap_addr", 32'(last_addr), 32'h00000);

    // AUD3LCL write during channel 3's restart slot.
    write_reg(8'h68, 16'h0001);
    write_reg(8'h69, 16'h0000);
    run_line(4'h8, 4'h8, 4'h8, 4'h8, 9'h014, 8'h69, 16'h0010, 1'b0);
    check("ch3_old_lc", 32'(last_addr), 32'h08000);
    run_line(4'h8, 4'h8, 4'h8, 4'h8, 9'h1FF, 8'h00, 16'h0, 1'b0);
    check("ch3_new_lc", 32'(last_addr), 32'h08008);

    // Randomized lines against the model.
    for (int l = 0; l < 150; l++) begin
      sel = $urandom_range(0, 9);
      if (sel < 8) ra = 8'(80 + 8 * (sel / 2) + sel % 2);
      else ra = 8'($urandom);
      run_line(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
               ($urandom_range(0, 3) == 0) ? 9'h1FF : 9'($urandom_range(0, 23)),
               ra, 16'($urandom), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
